// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem request, instruction presented valid/ready to decode.
// Latency: instr_valid one cycle after rvalid; backpressure: holds the instruction and stops fetching until instr_ready.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] pc;
  logic            redirect_take;
  logic            capture;

  // Redirect outranks gnt/rvalid/ready; a granted-but-unreturned fetch must be drained.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_REQ;
      S_REQ: begin
        if (redirect)      next_state = imem_gnt ? S_DRAIN : S_REQ;
        else if (imem_gnt) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)         next_state = imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem_rvalid) next_state = S_HOLD;
      end
      S_HOLD: begin
        if (redirect || instr_ready) next_state = S_REQ;
      end
      S_DRAIN: begin
        if (imem_rvalid) next_state = S_REQ;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign redirect_take = redirect && (state != S_IDLE);
  assign capture       = (state == S_WAIT) && imem_rvalid && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= next_state;
      if (redirect_take) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (capture) begin
        pc <= pc + XLEN'(4);
      end
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign opcode      = instr[6:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that drives the 32-bit instruction word, and with it the 7-bit opcode, into the control decoder. It holds the program counter, fetches from instruction memory with one request outstanding, and presents each instruction on a valid/ready output. Execute-stage redirects (taken branch, jal, jalr) reload the PC and squash in-flight fetches. It sits between instruction memory and the `control` decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- XLEN, 32, address/data width; only 32 is supported

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  XLEN  instruction word
- instr_valid  out  1  instr/opcode/instr_pc valid
- instr  out  XLEN  registered instruction word
- opcode  out  7  instr[6:0], to control decoder
- instr_pc  out  XLEN  address of instr
- instr_ready  in  1  decoder consumes instruction
- redirect  in  1  load new PC, squash
- redirect_pc  in  XLEN  target; bits [1:0] forced to 0

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Only one memory request may be outstanding.
- Reset (async, rst_n low): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, instr_pc=0.
- IDLE -> REQ unconditionally on the first clock edge after rst_n rises.
- REQ: imem_req=1, imem_addr=pc. On gnt, go to WAIT. Req and addr hold stable until gnt.
- WAIT: imem_req=0. On rvalid, register instr=rdata, instr_pc=pc, instr_valid=1, pc<=pc+4 (mod 2^32), then go to HOLD.
- HOLD: instr_valid=1, outputs stable. On instr_ready, set instr_valid<=0 and go to REQ.
- DRAIN: imem_req=0. Wait for rvalid, discard the data, then go to REQ.
- Redirect has priority over every other event, in any state except IDLE. It sets pc<=redirect_pc&~3 and instr_valid<=0. Next state:
  - REQ without gnt: stay in REQ. imem_addr changes to the new pc (this is the only permitted change while req is held).
  - REQ with gnt in the same cycle: DRAIN.
  - WAIT without rvalid: DRAIN.
  - WAIT with rvalid in the same cycle: data is discarded; go to REQ.
  - HOLD: instruction is dropped even if instr_ready; go to REQ.
  - DRAIN: stay in DRAIN.
  - DRAIN with rvalid in the same cycle: REQ.
- A redirect in IDLE is ignored.
- rvalid outside WAIT/DRAIN is a protocol error and is ignored.

## Timing
- Fetch latency: gnt at cycle N, rvalid at N+k gives instr_valid=1 from N+k+1.
- Throughput with zero-wait memory (gnt in REQ cycle, rvalid next cycle) and instr_ready always high: one instruction every 3 cycles (REQ, WAIT, HOLD).
- Redirect at cycle N gives instr_valid=0 from N+1. The first request to the new pc is at N+1 unless the state is DRAIN.
- All outputs are registered or decoded from state and registers. There is no combinational path from any input to any output, except that imem_addr follows pc, which is a register.
- Mid-operation reset clears all state immediately. Responses pending in memory after reset are the memory's responsibility.

## Test plan
- Reset, then zero-wait memory returning 32'h0000_0033 at 0x0, 32'h0000_0023 at 0x4, 32'h0000_0013 at 0x8, instr_ready=1 -> opcodes 0110011, 0100011, 0010011 with instr_pc 0, 4, 8, one every 3 cycles.
- gnt delayed 3 cycles -> imem_req and imem_addr=0x0 held stable for all 4 cycles; instr_valid rises 1 cycle after rvalid.
- instr_ready low for 5 cycles in HOLD -> instr, opcode and instr_pc stable; no imem_req issued.
- Redirect to 0x103 during WAIT, late rvalid with 32'h0000_006F -> data discarded; next imem_addr=0x100; no instr_valid for the stale word.
- Redirect in the same cycle as gnt, and separately in the same cycle as rvalid -> DRAIN then REQ, and direct REQ, respectively; pc=target in both.
- pc=32'hFFFF_FFFC fetched -> next imem_addr=0x0 (wrap). rst_n pulsed low during WAIT -> outputs zero asynchronously; next imem_addr=RESET_PC.
